// File: rtl/mem_stage_ctrl_pkg.sv
// Shared LC-3b types for the MEM stage: word/register aliases, memory op codes
// and the MEM-access FSM state encoding.
package mem_stage_ctrl_pkg;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;

  typedef enum logic [2:0] {
    MEMOP_NONE = 3'd0,
    MEMOP_LDR  = 3'd1,
    MEMOP_LDB  = 3'd2,
    MEMOP_STR  = 3'd3,
    MEMOP_STB  = 3'd4,
    MEMOP_LDI  = 3'd5,
    MEMOP_STI  = 3'd6
  } lc3b_memop;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_ACC1 = 2'd1,
    MS_ACC2 = 2'd2,
    MS_DONE = 2'd3
  } lc3b_mem_state;

  function automatic logic memop_is_load(lc3b_memop op);
    return (op == MEMOP_LDR) || (op == MEMOP_LDB) || (op == MEMOP_LDI);
  endfunction

  function automatic logic memop_is_store(lc3b_memop op);
    return (op == MEMOP_STR) || (op == MEMOP_STB) || (op == MEMOP_STI);
  endfunction

  function automatic logic memop_is_indirect(lc3b_memop op);
    return (op == MEMOP_LDI) || (op == MEMOP_STI);
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_byte_lane.sv
// Combinational lane steering: aligned address, replicated store data,
// byte-enable mask and zero-extended byte loads.
module mem_byte_lane
  import mem_stage_ctrl_pkg::*;
(
  input  lc3b_memop  op,
  input  logic       word_access,
  input  lc3b_word   addr,
  input  lc3b_word   store_data,
  input  lc3b_word   rdata,
  output lc3b_word   aligned_addr,
  output lc3b_word   wdata,
  output logic [1:0] byte_enable,
  output lc3b_word   load_fmt
);

  logic byte_store;
  logic byte_load;

  // word_access forces word semantics for the final indirect access
  assign byte_store   = !word_access && (op == MEMOP_STB);
  assign byte_load    = !word_access && (op == MEMOP_LDB);

  assign aligned_addr = {addr[15:1], 1'b0};
  assign wdata        = byte_store ? {store_data[7:0], store_data[7:0]} : store_data;
  assign byte_enable  = byte_store ? (addr[0] ? 2'b10 : 2'b01) : 2'b11;
  assign load_fmt     = byte_load ? {8'h00, (addr[0] ? rdata[15:8] : rdata[7:0])}
                                  : rdata;

endmodule

// File: rtl/mem_stage_ctrl.sv
// LC-3b MEM-stage data-memory controller: sequences single and indirect
// accesses against a handshaked memory and stalls the pipeline meanwhile.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int INDIRECT_EN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [2:0]  mem_op,
  input  logic [15:0] addr_in,
  input  logic [15:0] store_data_in,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [15:0] dmem_address,
  output logic [15:0] dmem_wdata,
  output logic [1:0]  dmem_byte_enable,
  output logic [15:0] load_data,
  output logic        load_data_valid,
  output logic        stall_pipeline
);

  localparam bit IND_EN = (INDIRECT_EN != 0);

  lc3b_mem_state state, state_next;
  lc3b_memop     op_in, op_q;
  lc3b_word      addr_q, sd_q, ptr_q, load_q;

  logic          latch_en, ptr_en, ld_en;
  logic          indirect;
  lc3b_word      lane_addr_in, lane_addr, lane_wdata, lane_load;
  logic [1:0]    lane_be;

  assign op_in        = lc3b_memop'(mem_op);
  assign indirect     = IND_EN && memop_is_indirect(op_q);
  assign lane_addr_in = (state == MS_ACC2) ? ptr_q : addr_q;

  mem_byte_lane u_lane (
    .op           (op_q),
    .word_access  (state == MS_ACC2),
    .addr         (lane_addr_in),
    .store_data   (sd_q),
    .rdata        (dmem_rdata),
    .aligned_addr (lane_addr),
    .wdata        (lane_wdata),
    .byte_enable  (lane_be),
    .load_fmt     (lane_load)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= MS_IDLE;
      op_q   <= MEMOP_NONE;
      addr_q <= '0;
      sd_q   <= '0;
      ptr_q  <= '0;
      load_q <= '0;
    end else begin
      state <= state_next;
      if (latch_en) begin
        op_q   <= op_in;
        addr_q <= addr_in;
        sd_q   <= store_data_in;
      end
      if (ptr_en) ptr_q  <= dmem_rdata;
      if (ld_en)  load_q <= lane_load;
    end
  end

  always_comb begin
    state_next       = state;
    latch_en         = 1'b0;
    ptr_en           = 1'b0;
    ld_en            = 1'b0;
    stall_pipeline   = 1'b0;
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    dmem_address     = '0;
    dmem_wdata       = '0;
    dmem_byte_enable = 2'b00;
    load_data_valid  = 1'b0;
    unique case (state)
      MS_IDLE: begin
        // undefined op encodings are treated like NONE
        if (valid_in && (memop_is_load(op_in) || memop_is_store(op_in))) begin
          stall_pipeline = 1'b1;
          latch_en       = 1'b1;
          state_next     = MS_ACC1;
        end
      end
      MS_ACC1: begin
        stall_pipeline   = 1'b1;
        dmem_read        = memop_is_load(op_q) || indirect;
        dmem_write       = memop_is_store(op_q) && !indirect;
        dmem_address     = lane_addr;
        dmem_wdata       = lane_wdata;
        dmem_byte_enable = lane_be;
        if (dmem_resp) begin
          if (indirect) begin
            ptr_en     = 1'b1;
            state_next = MS_ACC2;
          end else begin
            ld_en      = memop_is_load(op_q);
            state_next = MS_DONE;
          end
        end
      end
      MS_ACC2: begin
        stall_pipeline   = 1'b1;
        dmem_read        = memop_is_load(op_q);
        dmem_write       = memop_is_store(op_q);
        dmem_address     = lane_addr;
        dmem_wdata       = lane_wdata;
        dmem_byte_enable = lane_be;
        if (dmem_resp) begin
          ld_en      = memop_is_load(op_q);
          state_next = MS_DONE;
        end
      end
      MS_DONE: begin
        load_data_valid = memop_is_load(op_q);
        state_next      = MS_IDLE;
      end
      default: state_next = MS_IDLE;
    endcase
  end

  assign load_data = load_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed vector table, randomized transactions
// against a transaction-level model, and reset / idle corner sequences.
module tb_mem_stage_ctrl;
  import mem_stage_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [2:0]  mem_op;
  logic [15:0] addr_in, store_data_in, dmem_rdata;
  logic        dmem_resp;
  logic        dmem_read, dmem_write;
  logic [15:0] dmem_address, dmem_wdata, load_data;
  logic [1:0]  dmem_byte_enable;
  logic        load_data_valid, stall_pipeline;

  int checks   = 0;
  int failures = 0;

  mem_stage_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .valid_in         (valid_in),
    .mem_op           (mem_op),
    .addr_in          (addr_in),
    .store_data_in    (store_data_in),
    .dmem_rdata       (dmem_rdata),
    .dmem_resp        (dmem_resp),
    .dmem_read        (dmem_read),
    .dmem_write       (dmem_write),
    .dmem_address     (dmem_address),
    .dmem_wdata       (dmem_wdata),
    .dmem_byte_enable (dmem_byte_enable),
    .load_data        (load_data),
    .load_data_valid  (load_data_valid),
    .stall_pipeline   (stall_pipeline)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [2:0]  op;
    logic [15:0] addr, sd, rd0, rd1;
    int          lat0, lat1;
    logic [15:0] exp_addr0, exp_wdata0, exp_addr1, exp_load;
    logic [1:0]  exp_be0;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Transaction-level reference: what the memory should see and what a load returns.
  function automatic logic m_load(logic [2:0] op);
    return op == MEMOP_LDR || op == MEMOP_LDB || op == MEMOP_LDI;
  endfunction
  function automatic logic m_ind(logic [2:0] op);
    return op == MEMOP_LDI || op == MEMOP_STI;
  endfunction

  function automatic vec_t model(vec_t v);
    vec_t r = v;
    int lo, hi;
    lo = v.rd0 % 256;
    hi = v.rd0 / 256;
    r.exp_addr0  = v.addr - (v.addr % 2);
    r.exp_addr1  = v.rd0 - (v.rd0 % 2);
    r.exp_be0    = (v.op == MEMOP_STB) ? ((v.addr % 2 == 1) ? 2'd2 : 2'd1) : 2'd3;
    r.exp_wdata0 = (v.op == MEMOP_STB) ? 16'((v.sd % 256) * 257) : v.sd;
    case (v.op)
      MEMOP_LDR: r.exp_load = v.rd0;
      MEMOP_LDB: r.exp_load = 16'((v.addr % 2 == 1) ? hi : lo);
      MEMOP_LDI: r.exp_load = v.rd1;
      default:   r.exp_load = 16'h0;
    endcase
    return r;
  endfunction

  // Entered just after a posedge with the DUT idle; leaves it idle the same way.
  task automatic run_txn(input vec_t v);
    int n_acc, stall_cnt, lat;
    logic exp_rd, exp_wr;
    n_acc     = m_ind(v.op) ? 2 : 1;
    stall_cnt = 0;
    valid_in = 1'b1; mem_op = v.op; addr_in = v.addr; store_data_in = v.sd;
    dmem_resp = 1'b0; dmem_rdata = 16'($urandom);
    @(negedge clk);
    check("issue_stall", stall_pipeline, 1'b1);
    check("issue_noreq", {dmem_read, dmem_write}, 2'b00);
    if (stall_pipeline) stall_cnt++;
    for (int a = 0; a < n_acc; a++) begin
      lat    = (a == 0) ? v.lat0 : v.lat1;
      exp_rd = (a == 0) ? (m_load(v.op) || m_ind(v.op)) : (v.op == MEMOP_LDI);
      exp_wr = (a == 0) ? (!m_load(v.op) && !m_ind(v.op)) : (v.op == MEMOP_STI);
      for (int c = 0; c < lat; c++) begin
        @(posedge clk); #1;
        valid_in = 1'($urandom_range(0, 1)); mem_op = 3'($urandom_range(0, 7));
        addr_in = 16'($urandom); store_data_in = 16'($urandom);
        dmem_resp  = (c == lat - 1);
        dmem_rdata = (c == lat - 1) ? ((a == 0) ? v.rd0 : v.rd1) : 16'($urandom);
        @(negedge clk);
        if (stall_pipeline) stall_cnt++;
        check("acc_read", dmem_read, exp_rd);
        check("acc_write", dmem_write, exp_wr);
        check("acc_addr", dmem_address, (a == 0) ? v.exp_addr0 : v.exp_addr1);
        check("acc_be", dmem_byte_enable, (a == 0) ? v.exp_be0 : 2'b11);
        if (exp_wr) check("acc_wdata", dmem_wdata, (a == 0) ? v.exp_wdata0 : v.sd);
        check("acc_valid", load_data_valid, 1'b0);
      end
    end
    @(posedge clk); #1;
    dmem_resp = 1'b0; valid_in = 1'b0; mem_op = MEMOP_NONE;
    @(negedge clk);
    check("done_stall", stall_pipeline, 1'b0);
    check("done_noreq", {dmem_read, dmem_write}, 2'b00);
    check("done_valid", load_data_valid, m_load(v.op));
    if (m_load(v.op)) check("done_load", load_data, v.exp_load);
    check("stall_cycles", stall_cnt, 1 + v.lat0 + ((n_acc == 2) ? v.lat1 : 0));
    @(posedge clk); #1;
  endtask

  vec_t tbl[8];
  vec_t rv;

  initial begin
    reset = 1'b1; valid_in = 1'b0; mem_op = MEMOP_NONE; addr_in = '0;
    store_data_in = '0; dmem_rdata = '0; dmem_resp = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", {dmem_read, dmem_write, stall_pipeline, load_data_valid}, 4'b0);
    check("rst_addr", dmem_address, 16'h0);
    check("rst_wdata", dmem_wdata, 16'h0);
    check("rst_load", load_data, 16'h0);
    check("rst_be", dmem_byte_enable, 2'b00);
    @(posedge clk); #1; reset = 1'b0;

    //           op         addr      sd        rd0       rd1      l0 l1 addr0     wdata0    addr1     load      be0
    tbl[0] = '{MEMOP_LDR, 16'h1235, 16'h0000, 16'hBEEF, 16'h0000, 2, 1, 16'h1234, 16'h0000, 16'h0000, 16'hBEEF, 2'b11};
    tbl[1] = '{MEMOP_LDB, 16'h2001, 16'h0000, 16'hA55A, 16'h0000, 1, 1, 16'h2000, 16'h0000, 16'h0000, 16'h00A5, 2'b11};
    tbl[2] = '{MEMOP_LDB, 16'h2000, 16'h0000, 16'hA55A, 16'h0000, 1, 1, 16'h2000, 16'h0000, 16'h0000, 16'h005A, 2'b11};
    tbl[3] = '{MEMOP_STB, 16'h3001, 16'h00C3, 16'h0000, 16'h0000, 1, 1, 16'h3000, 16'hC3C3, 16'h0000, 16'h0000, 2'b10};
    tbl[4] = '{MEMOP_STR, 16'h3000, 16'h1234, 16'h0000, 16'h0000, 1, 1, 16'h3000, 16'h1234, 16'h0000, 16'h0000, 2'b11};
    tbl[5] = '{MEMOP_LDI, 16'h4000, 16'h0000, 16'h5002, 16'h1111, 1, 1, 16'h4000, 16'h0000, 16'h5002, 16'h1111, 2'b11};
    tbl[6] = '{MEMOP_STI, 16'h4001, 16'hABCD, 16'h6003, 16'h0000, 2, 3, 16'h4000, 16'hABCD, 16'h6002, 16'h0000, 2'b11};
    tbl[7] = '{MEMOP_STB, 16'h3000, 16'h12FE, 16'h0000, 16'h0000, 3, 1, 16'h3000, 16'hFEFE, 16'h0000, 16'h0000, 2'b01};
    for (int i = 0; i < 8; i++) run_txn(tbl[i]);

    // NONE with a stray response must not start anything.
    valid_in = 1'b1; mem_op = MEMOP_NONE; dmem_resp = 1'b1; dmem_rdata = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("none_stall", stall_pipeline, 1'b0);
      check("none_req", {dmem_read, dmem_write}, 2'b00);
      @(posedge clk); #1;
    end
    valid_in = 1'b0; dmem_resp = 1'b0;
    rv = '{MEMOP_LDR, 16'h0777, 16'h0, 16'h2468, 16'h0, 1, 1, 16'h0, 16'h0, 16'h0, 16'h0, 2'b11};
    run_txn(model(rv));

    // Reset during the final STI write; a late response must be ignored.
    valid_in = 1'b1; mem_op = MEMOP_STI; addr_in = 16'h4000; store_data_in = 16'h7777;
    @(posedge clk); #1;
    valid_in = 1'b0; mem_op = MEMOP_NONE; dmem_resp = 1'b1; dmem_rdata = 16'h5004;
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    @(negedge clk);
    check("sti_acc2_write", dmem_write, 1'b1);
    check("sti_acc2_addr", dmem_address, 16'h5004);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_write", dmem_write, 1'b0);
    check("rst_mid_stall", stall_pipeline, 1'b0);
    check("rst_mid_addr", dmem_address, 16'h0);
    @(posedge clk); #1;
    reset = 1'b0; dmem_resp = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("post_rst_req", {dmem_read, dmem_write}, 2'b00);
      check("post_rst_stall", stall_pipeline, 1'b0);
      check("post_rst_valid", load_data_valid, 1'b0);
      @(posedge clk); #1;
      dmem_resp = 1'b0;
    end

    for (int i = 0; i < 40; i++) begin
      rv.op   = 3'($urandom_range(1, 6));
      rv.addr = 16'($urandom); rv.sd = 16'($urandom);
      rv.rd0  = 16'($urandom); rv.rd1 = 16'($urandom);
      rv.lat0 = $urandom_range(1, 3); rv.lat1 = $urandom_range(1, 3);
      run_txn(model(rv));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
